wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Owns the single register-file write port (wn/d/we) at the pipeline writeback end.
//  Merges two result sources into one write per cycle:
//   - in-order pipeline WB results, which always have priority;
//   - out-of-band results from long-latency units (mul/div), queued in a small FIFO.
//  Exports pending-register flags so decode stalls on sources still queued.
//  Requests a one-cycle pipeline bubble if a queued result starves.
// PARAMETERS
//  DEPTH     4  long-latency result FIFO entries; power of 2, >=2
//  MAX_WAIT  8  cycles the FIFO head may wait unpopped before stall_req asserts; >=1
// PORTS
//  clk         in   1   clock; all state updates on posedge
//  clr         in   1   asynchronous, active-high reset
//  wb_valid    in   1   pipeline WB result valid this cycle
//  wb_rn       in   5   pipeline destination register
//  wb_d        in   32  pipeline result data
//  ll_valid    in   1   long-latency result offered
//  ll_rn       in   5   long-latency destination register
//  ll_d        in   32  long-latency result data
//  ll_ready    out  1   FIFO can accept; transfer occurs when ll_valid & ll_ready
//  chk_rna     in   5   decode source register A to check
//  chk_rnb     in   5   decode source register B to check
//  chk_pend_a  out  1   chk_rna has a live queued write
//  chk_pend_b  out  1   chk_rnb has a live queued write
//  stall_req   out  1   request a WB bubble next cycle
//  wn          out  5   regfile write register, registered
//  d           out  32  regfile write data, registered
//  we          out  1   regfile write enable, registered
// BEHAVIOUR
//  Reset (clr=1, async):
//   - FIFO empty; all entry live bits 0; wait counter 0.
//   - wn=0, d=0, we=0, stall_req=0, ll_ready=1.
//  Port select, evaluated every cycle:
//   - wb_valid & wb_rn!=0: next wn/d = wb_rn/wb_d, we=1. FIFO not popped.
//   - else if FIFO non-empty: pop head.
//     Head live: wn/d = head rn/data, we=1. Head dead: we=0, wn/d hold.
//   - else we=0, wn/d hold.
//  Latency: a source is presented at cycle N, so we/wn/d show it at N+1
//   and the regfile commits at edge N+2.
//  Enqueue:
//   - ll_ready = !full; it depends only on occupancy, not on a same-cycle pop.
//   - ll_valid & ll_ready & ll_rn!=0: push {rn,d}, live=1.
//   - ll_rn==0: handshake completes; result is discarded, not pushed.
//   - Push and pop in the same cycle are both legal, including when full (no push then)
//     and when empty (the new entry is not poppable until the next cycle).
//  Cancellation (WAW):
//   - A pipeline write with rn!=0 clears the live bit of every queued entry whose rn matches.
//   - It does not affect an entry pushed in that same cycle; the pushed entry is younger.
//   - Dead entries are popped without writing.
//  Pending check:
//   - chk_pend_x = OR over queued entries of (live & rn==chk_rnx), combinational.
//   - Register 0 never reports pending.
//  Starvation:
//   - The wait counter increments each cycle the FIFO is non-empty and not popped,
//     saturating at MAX_WAIT. It clears on any pop or when the FIFO is empty.
//   - stall_req = (counter==MAX_WAIT), registered.
//   - While stall_req=1 the pipeline holds wb_valid=0, so the next cycle pops.
//   - If wb_valid=1 anyway, the pipeline write still wins and stall_req stays high.
//  Reset mid-operation drops all queued entries; no write is issued for them.
// TESTING
//  - Reset: clr=1 mid-traffic -> next cycle we=0, wn=0, d=0, ll_ready=1, stall_req=0;
//    queued entries never written.
//  - Priority: wb_valid=1 (r5,0x11) with ll push (r6,0x22) -> cycle+1 we/wn/d=1/5/0x11;
//    next idle cycle -> 1/6/0x22.
//  - Full: 4 ll pushes with wb_valid held 1 -> ll_ready=0 after the 4th;
//    5th offer stalls until a pop.
//  - Cancel: push (r7,0xAA); pipeline writes r7=0xBB; then idle -> entry popped with we=0;
//    chk_pend for r7 drops to 0 once cancelled.
//  - Pending: push (r9,x) -> chk_rna=9 gives chk_pend_a=1; chk_rna=0 gives 0;
//    after pop, chk_pend_a=0.
//  - Starve: FIFO non-empty, wb_valid=1 with rn!=0 for 8 cycles -> stall_req=1;
//    wb_valid=0 -> head written, stall_req=0 next cycle.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Writeback-port bundle: pipeline result, long-latency offer,
// decode pending checks and the registered regfile write.
interface wb_port_arbiter_if;
  logic        wb_valid;
  logic [4:0]  wb_rn;
  logic [31:0] wb_d;
  logic        ll_valid;
  logic [4:0]  ll_rn;
  logic [31:0] ll_d;
  logic        ll_ready;
  logic [4:0]  chk_rna;
  logic [4:0]  chk_rnb;
  logic        chk_pend_a;
  logic        chk_pend_b;
  logic        stall_req;
  logic [4:0]  wn;
  logic [31:0] d;
  logic        we;

  modport slave (
    input  wb_valid, wb_rn, wb_d,
    input  ll_valid, ll_rn, ll_d,
    input  chk_rna, chk_rnb,
    output ll_ready, chk_pend_a, chk_pend_b,
    output stall_req, wn, d, we
  );

  modport master (
    output wb_valid, wb_rn, wb_d,
    output ll_valid, ll_rn, ll_d,
    output chk_rna, chk_rnb,
    input  ll_ready, chk_pend_a, chk_pend_b,
    input  stall_req, wn, d, we
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Regfile write-port owner: pipeline WB wins, long-latency results
// queue in a small FIFO with WAW cancellation and starvation bubbles.
module wb_port_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input logic clk,
  input logic clr,
  wb_port_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [4:0]       q_rn [DEPTH];
  logic [31:0]      q_d  [DEPTH];
  logic [DEPTH-1:0] q_live;
  logic [DEPTH-1:0] live_nxt;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic [WW-1:0]    wait_cnt;
  logic [WW-1:0]    wait_nxt;

  logic        full;
  logic        empty;
  logic        wb_take;
  logic        push;
  logic        pop;
  logic        head_live;
  logic        pend_a;
  logic        pend_b;
  logic        stall_q;
  logic        we_q;
  logic [4:0]  wn_q;
  logic [31:0] d_q;

  assign full      = count == (AW+1)'(DEPTH);
  assign empty     = count == '0;
  assign wb_take   = bus.wb_valid & (|bus.wb_rn);
  assign push      = bus.ll_valid & ~full & (|bus.ll_rn);
  assign pop       = ~wb_take & ~empty;
  assign head_live = q_live[rd_ptr];

  assign bus.ll_ready   = ~full;
  assign bus.chk_pend_a = pend_a & (|bus.chk_rna);
  assign bus.chk_pend_b = pend_b & (|bus.chk_rnb);
  assign bus.stall_req  = stall_q;
  assign bus.we         = we_q;
  assign bus.wn         = wn_q;
  assign bus.d          = d_q;

  // Kill is applied before the push so a same-cycle entry stays live.
  always_comb begin
    pend_a   = 1'b0;
    pend_b   = 1'b0;
    live_nxt = q_live;
    for (int i = 0; i < DEPTH; i++) begin
      pend_a |= q_live[i] & (q_rn[i] == bus.chk_rna);
      pend_b |= q_live[i] & (q_rn[i] == bus.chk_rnb);
      if (wb_take && q_rn[i] == bus.wb_rn)
        live_nxt[i] = 1'b0;
    end
    if (pop)
      live_nxt[rd_ptr] = 1'b0;
    if (push)
      live_nxt[wr_ptr] = 1'b1;
  end

  always_comb begin
    wait_nxt = wait_cnt;
    if (empty || pop)
      wait_nxt = '0;
    else if (wait_cnt != WW'(MAX_WAIT))
      wait_nxt = wait_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      q_live   <= '0;
      wait_cnt <= '0;
      stall_q  <= 1'b0;
      we_q     <= 1'b0;
      wn_q     <= '0;
      d_q      <= '0;
    end else begin
      q_live   <= live_nxt;
      wait_cnt <= wait_nxt;
      stall_q  <= wait_nxt == WW'(MAX_WAIT);
      count    <= count + {{AW{1'b0}}, push}
                        - {{AW{1'b0}}, pop};
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      we_q <= wb_take | (pop & head_live);
      if (wb_take) begin
        wn_q <= bus.wb_rn;
        d_q  <= bus.wb_d;
      end else if (pop && head_live) begin
        wn_q <= q_rn[rd_ptr];
        d_q  <= q_d[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rn[wr_ptr] <= bus.ll_rn;
      q_d[wr_ptr]  <= bus.ll_d;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a queue-based reference model
// predicts each cycle's write port, pending flags and stall request.
module tb_wb_port_arbiter;
  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(
    .DEPTH(DEPTH),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  wn;
    logic [31:0] d;
    logic        st;
  } exp_t;

  exp_t        sb [$];
  logic [4:0]  m_rn [$];
  logic [31:0] m_d [$];
  bit          m_live [$];
  logic [4:0]  m_wn;
  logic [31:0] m_dd;
  int          m_wait;
  int          n_chk;
  int          n_pass;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
  endtask

  task automatic model_clear();
    m_rn.delete();
    m_d.delete();
    m_live.delete();
    m_wn   = '0;
    m_dd   = '0;
    m_wait = 0;
  endtask

  task automatic step(input logic wv, input logic [4:0] wr,
                      input logic [31:0] wd, input logic lv,
                      input logic [4:0] lr, input logic [31:0] ld,
                      input logic [4:0] ca, input logic [4:0] cb);
    exp_t e;
    bit take, popped, rdy, pa, pb, hl;
    int pre;
    logic [4:0]  hr;
    logic [31:0] hd;
    bus.wb_valid = wv;
    bus.wb_rn    = wr;
    bus.wb_d     = wd;
    bus.ll_valid = lv;
    bus.ll_rn    = lr;
    bus.ll_d     = ld;
    bus.chk_rna  = ca;
    bus.chk_rnb  = cb;
    #1;
    rdy = m_rn.size() < DEPTH;
    pa = 0;
    pb = 0;
    foreach (m_rn[i]) begin
      if (m_live[i] && m_rn[i] == ca && ca != 0) pa = 1;
      if (m_live[i] && m_rn[i] == cb && cb != 0) pb = 1;
    end
    check("ll_ready", bus.ll_ready, rdy);
    check("pend_a", bus.chk_pend_a, pa);
    check("pend_b", bus.chk_pend_b, pb);
    take   = wv && wr != 0;
    popped = 0;
    pre    = m_rn.size();
    e.we   = 0;
    if (take) begin
      e.we = 1;
      m_wn = wr;
      m_dd = wd;
      foreach (m_rn[i])
        if (m_rn[i] == wr) m_live[i] = 0;
    end else if (pre > 0) begin
      popped = 1;
      hr = m_rn.pop_front();
      hd = m_d.pop_front();
      hl = m_live.pop_front();
      if (hl) begin
        e.we = 1;
        m_wn = hr;
        m_dd = hd;
      end
    end
    if (pre == 0 || popped)
      m_wait = 0;
    else if (m_wait < MAX_WAIT)
      m_wait++;
    if (lv && rdy && lr != 0) begin
      m_rn.push_back(lr);
      m_d.push_back(ld);
      m_live.push_back(1);
    end
    e.wn = m_wn;
    e.d  = m_dd;
    e.st = m_wait == MAX_WAIT;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("we", bus.we, e.we);
    check("wn", bus.wn, e.wn);
    check("d", bus.d, e.d);
    check("stall_req", bus.stall_req, e.st);
  endtask

  task automatic idle(input int n, input logic [4:0] ca);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 0, 0, ca, 0);
  endtask

  task automatic do_reset();
    clr = 1'b1;
    #1;
    check("rst_we", bus.we, 0);
    check("rst_wn", bus.wn, 0);
    check("rst_d", bus.d, 0);
    check("rst_ready", bus.ll_ready, 1);
    check("rst_stall", bus.stall_req, 0);
    model_clear();
    bus.wb_valid = 0;
    bus.ll_valid = 0;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    model_clear();
    bus.wb_valid = 0;
    bus.wb_rn    = 0;
    bus.wb_d     = 0;
    bus.ll_valid = 0;
    bus.ll_rn    = 0;
    bus.ll_d     = 0;
    bus.chk_rna  = 0;
    bus.chk_rnb  = 0;
    @(posedge clk);
    #1;
    check("init_we", bus.we, 0);
    check("init_wn", bus.wn, 0);
    check("init_ready", bus.ll_ready, 1);
    check("init_stall", bus.stall_req, 0);
    clr = 1'b0;

    // priority: pipeline first, queued result on next idle cycle
    step(1, 5, 32'h11, 1, 6, 32'h22, 0, 0);
    check("prio_wn", bus.wn, 5);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("prio_ll_wn", bus.wn, 6);
    check("prio_ll_d", bus.d, 32'h22);

    // full FIFO with pipeline holding the port
    for (int k = 0; k < 4; k++)
      step(1, 1, k, 1, 5'(20 + k), 32'h100 + k, 0, 0);
    check("full_ready", bus.ll_ready, 0);
    step(1, 1, 9, 1, 25, 32'h200, 22, 0);
    step(0, 0, 0, 1, 25, 32'h200, 0, 0);
    step(0, 0, 0, 1, 25, 32'h200, 0, 25);
    idle(6, 25);

    // WAW cancel
    step(0, 0, 0, 1, 7, 32'hAA, 7, 0);
    step(1, 7, 32'hBB, 0, 0, 0, 7, 0);
    step(0, 0, 0, 0, 0, 0, 7, 7);
    check("cancel_we", bus.we, 0);
    check("cancel_wn", bus.wn, 7);
    check("cancel_d", bus.d, 32'hBB);

    // same-cycle push of a matching rn survives the cancel
    step(1, 12, 32'h1, 1, 12, 32'h2, 0, 0);
    step(0, 0, 0, 0, 0, 0, 12, 0);
    check("young_d", bus.d, 32'h2);

    // pending flags, incl. r0 and rn==0 discard
    step(0, 0, 0, 1, 9, 32'h99, 0, 0);
    step(1, 2, 32'h3, 1, 0, 32'h55, 9, 0);
    step(1, 2, 32'h4, 0, 0, 0, 0, 9);
    step(0, 0, 0, 0, 0, 0, 9, 9);
    idle(2, 9);

    // starvation
    step(0, 0, 0, 1, 10, 32'hCAFE, 0, 0);
    for (int k = 0; k < MAX_WAIT; k++)
      step(1, 3, k, 0, 0, 0, 10, 0);
    check("starve_stall", bus.stall_req, 1);
    step(1, 3, 32'h77, 0, 0, 0, 0, 0);
    check("starve_hold", bus.stall_req, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("starve_wn", bus.wn, 10);
    check("starve_clear", bus.stall_req, 0);

    // reset mid-traffic: queued entries must never be written
    step(1, 4, 1, 1, 13, 32'h13, 0, 0);
    step(1, 4, 2, 1, 14, 32'h14, 0, 0);
    do_reset();
    idle(4, 13);

    // random traffic on a small register range
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           $urandom, 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), $urandom,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    end
    idle(8, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
